// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Write-port arbiter and single-load scoreboard for a 2**D x W register
//   file. Shares the one write port between ALU writeback and memory load
//   returns. A one-entry skid buffer absorbs ALU/load collisions, and Stall
//   holds decode on read-after-load, write-after-load and port conflicts.
//
//   Optional feature macro: REG_WB_TIMEOUT_EN (load-return timeout + LoadErr).
//
// Ports
//   Clk, Reset           : clock, synchronous active-high reset
//   AluWe/AluWaddr/AluData : ALU writeback request
//   LoadIssue/LoadDest   : load issue and its destination register
//   MemValid/MemData     : load return data
//   RenA/RenB/RaddrA/B   : decode read-port usage, for hazard detection
//   WriteEn/Waddr/DataIn : register file write port (combinational)
//   Stall                : hold decode/issue (combinational)
//   LoadBusy             : a load is outstanding (registered)
//   LoadErr              : one-cycle pulse on load timeout (registered)
module reg_wb_arbiter #(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         AluWe,
    input  logic [D-1:0] AluWaddr,
    input  logic [W-1:0] AluData,
    input  logic         LoadIssue,
    input  logic [D-1:0] LoadDest,
    input  logic         MemValid,
    input  logic [W-1:0] MemData,
    input  logic         RenA,
    input  logic         RenB,
    input  logic [D-1:0] RaddrA,
    input  logic [D-1:0] RaddrB,
    output logic         WriteEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         Stall,
    output logic         LoadBusy,
    output logic         LoadErr
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t       state_q, state_d;
    logic [D-1:0] dest_q, dest_d;
    logic         skid_v_q, skid_v_d;
    logic [D-1:0] skid_addr_q, skid_addr_d;
    logic [W-1:0] skid_data_q, skid_data_d;

    logic waiting, load_ret, alu_acc, issue_acc, timeout;
    logic rd_hit_dest, rd_hit_skid;

`ifdef REG_WB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT;
`endif

    always_comb begin
        waiting     = (state_q == WAIT_MEM);
        load_ret    = waiting && MemValid;
        rd_hit_dest = (RenA && RaddrA == dest_q) || (RenB && RaddrB == dest_q);
        rd_hit_skid = (RenA && RaddrA == skid_addr_q) || (RenB && RaddrB == skid_addr_q);

        // Any stalled request is simply not accepted this cycle; upstream
        // holds it stable and retries.
        Stall = !Reset && ((waiting && rd_hit_dest) ||
                           (skid_v_q && rd_hit_skid) ||
                           (waiting && AluWe && AluWaddr == dest_q) ||
                           (waiting && LoadIssue && !MemValid) ||
                           (load_ret && AluWe && skid_v_q));
        alu_acc   = AluWe && !Stall;
        issue_acc = LoadIssue && !Stall;

        // Write port: load return > skid drain > ALU passthrough.
        WriteEn = 1'b0;
        Waddr   = '0;
        DataIn  = '0;
        if (!Reset) begin
            if (load_ret) begin
                WriteEn = 1'b1;
                Waddr   = dest_q;
                DataIn  = MemData;
            end else if (skid_v_q) begin
                WriteEn = 1'b1;
                Waddr   = skid_addr_q;
                DataIn  = skid_data_q;
            end else if (alu_acc) begin
                WriteEn = 1'b1;
                Waddr   = AluWaddr;
                DataIn  = AluData;
            end
        end

        // Skid: capture on collision; while draining, a new ALU write
        // refills it so ALU writes land in issue order.
        skid_v_d    = skid_v_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        if (load_ret || skid_v_q) begin
            if (alu_acc) begin
                skid_v_d    = 1'b1;
                skid_addr_d = AluWaddr;
                skid_data_d = AluData;
            end else if (!load_ret) begin
                skid_v_d = 1'b0;
            end
        end

        state_d = state_q;
        dest_d  = dest_q;
        timeout = 1'b0;
`ifdef REG_WB_TIMEOUT_EN
        timeout = waiting && !MemValid && (cnt_q == CW'(TIMEOUT - 1));
`endif
        case (state_q)
            IDLE: begin
                if (issue_acc) begin
                    state_d = WAIT_MEM;
                    dest_d  = LoadDest;
                end
            end
            WAIT_MEM: begin
                if (MemValid) begin
                    if (issue_acc) dest_d = LoadDest;
                    else           state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef REG_WB_TIMEOUT_EN
        // Counter restarts on every new load, including back-to-back issue.
        cnt_d = cnt_q;
        if (state_d == WAIT_MEM && (!waiting || load_ret)) cnt_d = '0;
        else if (waiting && !MemValid)                     cnt_d = cnt_q + CW'(1);
        err_d = timeout;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            skid_v_q    <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
`ifdef REG_WB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            skid_v_q    <= skid_v_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
`ifdef REG_WB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign LoadBusy = (state_q == WAIT_MEM);
`ifdef REG_WB_TIMEOUT_EN
    assign LoadErr = err_q;
`else
    assign LoadErr = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter. Expected register-file writes are queued as
// stimulus is driven and matched in order against DUT writes at negedge;
// Stall/LoadBusy/LoadErr and write timing are checked directly.
module tb_reg_wb_arbiter;
    localparam int W = 8, D = 4, TIMEOUT = 15;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         AluWe, LoadIssue, MemValid, RenA, RenB;
    logic [D-1:0] AluWaddr, LoadDest, RaddrA, RaddrB;
    logic [W-1:0] AluData, MemData;
    logic         WriteEn, Stall, LoadBusy, LoadErr;
    logic [D-1:0] Waddr;
    logic [W-1:0] DataIn;

    typedef struct packed {
        logic [D-1:0] a;
        logic [W-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0, n_bad = 0;

    reg_wb_arbiter #(.W(W), .D(D), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluWe(AluWe), .AluWaddr(AluWaddr), .AluData(AluData),
        .LoadIssue(LoadIssue), .LoadDest(LoadDest),
        .MemValid(MemValid), .MemData(MemData),
        .RenA(RenA), .RenB(RenB), .RaddrA(RaddrA), .RaddrB(RaddrB),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Stall(Stall), .LoadBusy(LoadBusy), .LoadErr(LoadErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        AluWe = 0; AluWaddr = 0; AluData = 0;
        LoadIssue = 0; LoadDest = 0;
        MemValid = 0; MemData = 0;
        RenA = 0; RenB = 0; RaddrA = 0; RaddrB = 0;
    endtask

    task automatic push(input logic [D-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every DUT write must match the next expected write.
    always @(negedge Clk) begin
        if (WriteEn === 1'b1) begin
            if (exp_q.size() == 0) chk("unexp_wr", WriteEn, 1'b0);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr", {Waddr, DataIn}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        Reset = 1;
        tick(); tick();
        #2;
        chk("rst_we", WriteEn, 0);
        chk("rst_waddr", Waddr, 0);
        chk("rst_data", DataIn, 0);
        chk("rst_stall", Stall, 0);
        chk("rst_busy", LoadBusy, 0);
        chk("rst_err", LoadErr, 0);
        Reset = 0;
        tick();

        // ALU passthrough, zero latency
        AluWe = 1; AluWaddr = 3; AluData = 8'h5A; push(3, 8'h5A);
        #2;
        chk("alu_we", WriteEn, 1);
        chk("alu_wd", {Waddr, DataIn}, {4'd3, 8'h5A});
        chk("alu_stall", Stall, 0);
        tick(); clr();

        // Load/ALU collision: skid write lands next cycle
        LoadIssue = 1; LoadDest = 7;
        #2 chk("iss_stall", Stall, 0);
        tick(); clr();
        chk("busy_rise", LoadBusy, 1);
        tick();
        MemValid = 1; MemData = 8'h11; AluWe = 1; AluWaddr = 2; AluData = 8'h22;
        push(7, 8'h11); push(2, 8'h22);
        #2;
        chk("col_wa", Waddr, 7);
        chk("col_stall", Stall, 0);
        tick(); clr();
        #2;
        chk("skid_we", WriteEn, 1);
        chk("skid_wd", {Waddr, DataIn}, {4'd2, 8'h22});
        chk("skid_stall", Stall, 0);
        chk("busy_fall", LoadBusy, 0);
        tick();
        #2 chk("skid_done", WriteEn, 0);

        // Read-after-load hazard through the return cycle
        LoadIssue = 1; LoadDest = 4;
        tick(); clr();
        RenA = 1; RaddrA = 4;
        for (int i = 0; i < 3; i++) begin
            #2 chk("raw_stall", Stall, 1);
            tick();
        end
        MemValid = 1; MemData = 8'h44; push(4, 8'h44);
        #2 chk("raw_ret_stall", Stall, 1);
        tick();
        MemValid = 0;
        #2 chk("raw_clear", Stall, 0);
        tick(); clr();

        // Back-to-back load
        LoadIssue = 1; LoadDest = 5;
        tick(); clr();
        tick();
        MemValid = 1; MemData = 8'h55; LoadIssue = 1; LoadDest = 9; push(5, 8'h55);
        #2 chk("b2b_stall", Stall, 0);
        tick(); clr();
        chk("b2b_busy", LoadBusy, 1);
        RenA = 1; RaddrA = 9;
        #2 chk("b2b_dest9", Stall, 1);
        RaddrA = 5;
        #1 chk("b2b_not5", Stall, 0);
        tick(); clr();
        MemValid = 1; MemData = 8'h99; push(9, 8'h99);
        tick(); clr();
        chk("b2b_busy_fall", LoadBusy, 0);

        // Double collision: skid full + ALU during load return
        LoadIssue = 1; LoadDest = 1;
        tick(); clr();
        MemValid = 1; MemData = 8'hA1; LoadIssue = 1; LoadDest = 6;
        AluWe = 1; AluWaddr = 2; AluData = 8'hB2;
        push(1, 8'hA1);
        #2 chk("dc_a_stall", Stall, 0);
        tick(); clr();
        MemValid = 1; MemData = 8'hC6; AluWe = 1; AluWaddr = 3; AluData = 8'hD3;
        push(6, 8'hC6);
        #2 chk("dc_stall", Stall, 1);
        tick();
        MemValid = 0;
        push(2, 8'hB2);
        #2;
        chk("dc_drain_wa", Waddr, 2);
        chk("dc_drain_stall", Stall, 0);
        tick(); clr();
        push(3, 8'hD3);
        #2 chk("dc_held_wd", {Waddr, DataIn}, {4'd3, 8'hD3});
        tick();
        #2 chk("dc_done", WriteEn, 0);
        tick();

        // Write-after-load ordering
        LoadIssue = 1; LoadDest = 8;
        tick(); clr();
        AluWe = 1; AluWaddr = 8; AluData = 8'h88;
        #2;
        chk("waw_stall", Stall, 1);
        chk("waw_nowr", WriteEn, 0);
        tick();
        MemValid = 1; MemData = 8'h80; push(8, 8'h80);
        #2 chk("waw_ret_stall", Stall, 1);
        tick();
        MemValid = 0; push(8, 8'h88);
        #2;
        chk("waw_go", Stall, 0);
        chk("waw_wd", {Waddr, DataIn}, {4'd8, 8'h88});
        tick(); clr();

        // MemValid while idle is ignored
        MemValid = 1; MemData = 8'hFF;
        #2 chk("idle_mv", WriteEn, 0);
        tick(); clr();

        // Read hazard against draining skid
        LoadIssue = 1; LoadDest = 10;
        tick(); clr();
        MemValid = 1; MemData = 8'hAA; AluWe = 1; AluWaddr = 12; AluData = 8'hCC;
        push(10, 8'hAA); push(12, 8'hCC);
        tick(); clr();
        RenB = 1; RaddrB = 12;
        #2 chk("skid_raw", Stall, 1);
        tick();
        #2 chk("skid_raw_clr", Stall, 0);
        tick(); clr();

`ifdef REG_WB_TIMEOUT_EN
        LoadIssue = 1; LoadDest = 11;
        tick(); clr();
        for (int i = 1; i <= TIMEOUT; i++) begin
            if (i == TIMEOUT) begin
                chk("to_pre_busy", LoadBusy, 1);
                chk("to_pre_err", LoadErr, 0);
            end
            tick();
        end
        chk("to_err", LoadErr, 1);
        chk("to_busy", LoadBusy, 0);
        MemValid = 1; MemData = 8'h77;
        #2 chk("to_late_mv", WriteEn, 0);
        tick(); clr();
        chk("to_err_pulse", LoadErr, 0);
`else
        LoadIssue = 1; LoadDest = 11;
        tick(); clr();
        for (int i = 0; i < 20; i++) tick();
        chk("nto_busy", LoadBusy, 1);
        chk("nto_err", LoadErr, 0);
        MemValid = 1; MemData = 8'h77; push(11, 8'h77);
        tick(); clr();
        chk("nto_busy_fall", LoadBusy, 0);
`endif

        // Reset mid-load
        LoadIssue = 1; LoadDest = 2;
        tick(); clr();
        tick();
        Reset = 1; AluWe = 1; AluWaddr = 5; AluData = 8'h5F; RenA = 1; RaddrA = 2;
        #2;
        chk("rr_we", WriteEn, 0);
        chk("rr_stall", Stall, 0);
        tick();
        Reset = 0; clr();
        #2;
        chk("rr_busy", LoadBusy, 0);
        chk("rr_err", LoadErr, 0);
        chk("rr_out", {WriteEn, Waddr, DataIn, Stall}, 0);
        MemValid = 1; MemData = 8'h33;
        #1 chk("rr_mv", WriteEn, 0);
        tick(); clr();
        tick(); tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and load scoreboard for the 2**D × W register file. It shares the file's single write port between the ALU writeback path and variable-latency memory load returns, and tracks one outstanding load. A one-entry skid buffer absorbs ALU/load collisions, and a Stall output holds decode on read-after-load, write-after-load and port-conflict hazards. It sits between decode/execute/memory and the register file's WriteEn/Waddr/DataIn inputs.

## Interface
- W, 8: register data width
- D, 4: register address width (2**D registers)
- TIMEOUT, 15: max cycles waiting for a load return (used only with REG_WB_TIMEOUT_EN)

- Clk  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- AluWe  in  1  ALU writeback request
- AluWaddr  in  D  ALU destination
- AluData  in  W  ALU result
- LoadIssue  in  1  load issued this cycle
- LoadDest  in  D  load destination register
- MemValid  in  1  load data returning this cycle
- MemData  in  W  load data
- RenA, RenB  in  1  decode uses read port A/B
- RaddrA, RaddrB  in  D  decode read addresses
- WriteEn  out  1  register file write enable
- Waddr  out  D  register file write address
- DataIn  out  W  register file write data
- Stall  out  1  hold decode/issue; upstream keeps all request inputs stable while high
- LoadBusy  out  1  a load is outstanding (registered)
- LoadErr  out  1  one-cycle pulse on load timeout (registered)

## Operation
- FSM: IDLE, WAIT_MEM. Registers: DestQ[D], SkidV, SkidAddr[D], SkidData[W], timeout counter.
- IDLE + LoadIssue: DestQ <= LoadDest, go to WAIT_MEM.
- WAIT_MEM + MemValid: load write retires.
  - LoadIssue in the same cycle: accept it, DestQ <= LoadDest, stay in WAIT_MEM.
  - Otherwise go to IDLE.
- WAIT_MEM + LoadIssue without MemValid: Stall=1, issue not accepted.
- MemValid in IDLE: ignored, no write.
- Write-port priority, in order:
  1. Load return (WAIT_MEM & MemValid): Waddr=DestQ, DataIn=MemData.
  2. Skid drain (SkidV): Waddr=SkidAddr.
  3. ALU passthrough (AluWe).
- AluWe while the load return owns the port:
  - SkidV=0: capture into skid.
  - SkidV=1: Stall=1, ALU request held.
- AluWe while the skid drains: ALU request replaces the skid contents (SkidV stays 1), so write order is preserved.
- Stall is also asserted in these cases (the Stall=1 requests are not accepted that cycle):
  - WAIT_MEM and (RenA & RaddrA==DestQ, or RenB & RaddrB==DestQ), including the return cycle.
  - SkidV and a read address matches SkidAddr with its Ren set.
  - WAIT_MEM & AluWe & AluWaddr==DestQ (write-after-load ordering).
- Outputs WriteEn, Waddr, DataIn and Stall are combinational from state and inputs. When WriteEn=0, Waddr=0 and DataIn=0.
- Reset, including mid-load: go to IDLE, SkidV=0, counter=0, and drop the outstanding load and skid contents. While Reset is high, WriteEn=0 and Stall=0.

## Timing
- Reset values: WriteEn 0, Waddr 0, DataIn 0, Stall 0, LoadBusy 0, LoadErr 0.
- ALU passthrough: zero latency; the register is written at the same edge.
- Skid-captured ALU write lands exactly 1 cycle after the collision.
- Minimum load latency is 1 cycle. MemValid is meaningful from the cycle after LoadIssue.
- LoadBusy rises the cycle after an accepted LoadIssue. It falls the cycle after the return, unless a back-to-back issue was accepted.

## Configuration
- REG_WB_TIMEOUT_EN defined:
  - Counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without MemValid.
  - When it reaches TIMEOUT: go to IDLE, no write, LoadErr=1 for exactly one cycle.
  - A MemValid arriving after the timeout is ignored.
- Undefined: no counter, WAIT_MEM waits indefinitely, LoadErr tied 0.

## Test plan
- ALU only: AluWe=1, AluWaddr=3, AluData=0x5A, idle state -> WriteEn=1, Waddr=3, DataIn=0x5A the same cycle, Stall=0.
- Collision: LoadIssue dest 7; 2 cycles later MemValid=1 data 0x11 together with AluWe addr 2 data 0x22:
  - Collision cycle: R7<=0x11.
  - Next cycle: R2<=0x22, with no stall.
- Read hazard: load dest 4 outstanding, RenA=1 RaddrA=4 -> Stall=1 every cycle through the return cycle, 0 the cycle after.
- Back-to-back: MemValid and LoadIssue dest 9 in the same cycle -> first load written, LoadBusy stays 1, DestQ=9.
- Double collision: skid full and another AluWe during a load return -> Stall=1. The held ALU write lands after the skid drains.
- REG_WB_TIMEOUT_EN, TIMEOUT=15: load issued, no MemValid:
  - LoadErr pulses 1 cycle after 15 waiting cycles, then LoadBusy=0.
  - A late MemValid produces no write.
  - Reset mid-WAIT_MEM: all outputs 0 the next cycle.
